// File: rtl/sig_mem_arbiter.sv
// Arbiter sharing one synchronous sample memory port between the ADC writer,
// the VGA fetcher and the CPU load path.
module sig_mem_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_wr_req,
  output logic                  o_wr_gnt,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_vga_req,
  output logic                  o_vga_gnt,
  input  logic [ADDR_WIDTH-1:0] i_vga_addr,
  output logic                  o_vga_rvalid,
  output logic [DATA_WIDTH-1:0] o_vga_rdata,
  input  logic                  i_cpu_req,
  output logic                  o_cpu_gnt,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  output logic                  o_cpu_rvalid,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    RR_VGA = 1'b0,
    RR_CPU = 1'b1
  } rr_e;

  rr_e                   r_rr_last;
  logic [CW-1:0]         r_starve;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_we;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [RD_LATENCY:0]   r_tag_v;
  logic [RD_LATENCY:0]   r_tag_vga;

  logic w_rd_any;
  logic w_starved;
  logic w_rd_win;
  logic w_pick_vga;
  logic w_rd_xfer;

  assign w_rd_any   = i_vga_req | i_cpu_req;
  assign w_starved  = (r_starve == CW'(STARVE_LIMIT));
  assign w_rd_win   = w_rd_any & (~i_wr_req | w_starved);
  // VGA takes the slot unless CPU is alone or VGA went last
  assign w_pick_vga = i_vga_req & (~i_cpu_req | (r_rr_last == RR_CPU));

  assign o_wr_gnt  = ~i_reset & i_wr_req & ~w_rd_win;
  assign o_vga_gnt = ~i_reset & w_rd_win & w_pick_vga;
  assign o_cpu_gnt = ~i_reset & w_rd_win & ~w_pick_vga;
  assign w_rd_xfer = o_vga_gnt | o_cpu_gnt;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rr_last   <= RR_CPU;
      r_starve    <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_tag_v     <= '0;
      r_tag_vga   <= '0;
    end else begin
      r_mem_we  <= o_wr_gnt;
      r_tag_v   <= {r_tag_v[RD_LATENCY-1:0], w_rd_xfer};
      r_tag_vga <= {r_tag_vga[RD_LATENCY-1:0], o_vga_gnt};
      if (o_wr_gnt) begin
        r_mem_addr  <= i_wr_addr;
        r_mem_wdata <= i_wr_data;
      end else if (o_vga_gnt) begin
        r_mem_addr <= i_vga_addr;
      end else if (o_cpu_gnt) begin
        r_mem_addr <= i_cpu_addr;
      end
      if (o_vga_gnt) begin
        r_rr_last <= RR_VGA;
      end else if (o_cpu_gnt) begin
        r_rr_last <= RR_CPU;
      end
      if (w_rd_xfer) begin
        r_starve <= '0;
      end else if (w_rd_any && o_wr_gnt && !w_starved) begin
        r_starve <= r_starve + CW'(1);
      end
    end
  end

  assign o_mem_addr   = r_mem_addr;
  assign o_mem_we     = r_mem_we;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_vga_rvalid = r_tag_v[RD_LATENCY] & r_tag_vga[RD_LATENCY];
  assign o_cpu_rvalid = r_tag_v[RD_LATENCY] & ~r_tag_vga[RD_LATENCY];
  assign o_vga_rdata  = i_mem_rdata;
  assign o_cpu_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_sig_mem_arbiter.sv
// Bench for sig_mem_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_sig_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int L  = 1;
  localparam int SL = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req, vga_req, cpu_req;
  logic [AW-1:0] wr_addr, vga_addr, cpu_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt, vga_gnt, cpu_gnt;
  logic          vga_rvalid, cpu_rvalid;
  logic [DW-1:0] vga_rdata, cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  sig_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .RD_LATENCY(L), .STARVE_LIMIT(SL)
  ) dut (
    .i_clock(clk), .i_reset(rst),
    .i_wr_req(wr_req), .o_wr_gnt(wr_gnt),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_vga_req(vga_req), .o_vga_gnt(vga_gnt),
    .i_vga_addr(vga_addr),
    .o_vga_rvalid(vga_rvalid), .o_vga_rdata(vga_rdata),
    .i_cpu_req(cpu_req), .o_cpu_gnt(cpu_gnt),
    .i_cpu_addr(cpu_addr),
    .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // Sample memory: contents = address after reset, L-cycle read pipe
  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] rpipe [0:L-1];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) mem[i] <= DW'(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    rpipe[0] <= mem[mem_addr];
    for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[L-1];

  // Reference model state
  typedef struct {
    int            due;
    bit            is_vga;
    logic [DW-1:0] d;
  } rd_t;

  rd_t           q[$];
  logic [DW-1:0] mm [0:4095];
  int            m_cnt;
  bit            m_last_cpu;
  logic [AW-1:0] e_addr;
  logic          e_we;
  logic [DW-1:0] e_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit a_gw, a_gv, a_gc;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 4096; i++) mm[i] = DW'(i);
    m_cnt      = 0;
    m_last_cpu = 1'b1;
    e_addr     = '0;
    e_we       = 1'b0;
    e_wdata    = '0;
  endtask

  // One cycle: called just after a falling edge with inputs applied
  task automatic step();
    bit ev, ec, xw, xv, xc, rdw;
    #1;
    if (rst) model_reset();
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_we", mem_we, e_we);
    chk("mem_wdata", mem_wdata, e_wdata);
    ev = (q.size() > 0) && (q[0].due == cyc) && q[0].is_vga;
    ec = (q.size() > 0) && (q[0].due == cyc) && !q[0].is_vga;
    chk("vga_rvalid", vga_rvalid, ev);
    chk("cpu_rvalid", cpu_rvalid, ec);
    if (ev) chk("vga_rdata", vga_rdata, q[0].d);
    if (ec) chk("cpu_rdata", cpu_rdata, q[0].d);
    if (ev || ec) void'(q.pop_front());
    xw = 0; xv = 0; xc = 0;
    if (!rst) begin
      rdw = (vga_req || cpu_req) && (!wr_req || m_cnt == SL);
      if (rdw) begin
        if (vga_req && cpu_req) xv = m_last_cpu;
        else xv = vga_req;
        xc = !xv;
      end else begin
        xw = wr_req;
      end
    end
    chk("wr_gnt", wr_gnt, xw);
    chk("vga_gnt", vga_gnt, xv);
    chk("cpu_gnt", cpu_gnt, xc);
    a_gw = wr_gnt; a_gv = vga_gnt; a_gc = cpu_gnt;
    if (xw) begin
      e_addr = wr_addr; e_we = 1'b1; e_wdata = wr_data;
      mm[wr_addr] = wr_data;
      if ((vga_req || cpu_req) && m_cnt < SL) m_cnt++;
    end else if (xv || xc) begin
      e_addr = xv ? vga_addr : cpu_addr;
      e_we = 1'b0;
      q.push_back('{cyc + 1 + L, xv, mm[e_addr]});
      m_last_cpu = xc;
      m_cnt = 0;
    end else begin
      e_we = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_reqs();
    wr_req = 0; vga_req = 0; cpu_req = 0;
  endtask

  task automatic do_reset();
    idle_reqs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int pw, pv, pc;
  logic [AW-1:0] hold_addr;
  bit exp_c;

  initial begin
    rst = 1'b1;
    idle_reqs();
    wr_addr = '0; vga_addr = '0; cpu_addr = '0; wr_data = '0;
    model_reset();
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // Single VGA read
    vga_req = 1; vga_addr = 12'h559;
    step();
    chk("t1_gnt", a_gv, 1);
    vga_req = 0;
    chk("t1_addr", mem_addr, 12'h559);
    chk("t1_we", mem_we, 0);
    step();
    chk("t1_rvalid", vga_rvalid, 1);
    chk("t1_rdata", vga_rdata, 32'h0000_0559);
    chk("t1_cpu_rv", cpu_rvalid, 0);
    step();

    // Reader round-robin
    do_reset();
    vga_req = 1; cpu_req = 1;
    vga_addr = 12'h100; cpu_addr = 12'h200;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_vga", a_gv, (k % 2) == 0);
      chk("rr_cpu", a_gc, (k % 2) == 1);
    end
    idle_reqs();
    repeat (3) step();

    // Write against read to the same address
    wr_req = 1; wr_addr = 12'h010; wr_data = 32'hDEAD_BEEF;
    cpu_req = 1; cpu_addr = 12'h010;
    step();
    chk("wr_first", a_gw, 1);
    wr_req = 0;
    chk("wr_pulse_hi", mem_we, 1);
    step();
    chk("cpu_next", a_gc, 1);
    cpu_req = 0;
    chk("wr_pulse_lo", mem_we, 0);
    step();
    chk("raw_rvalid", cpu_rvalid, 1);
    chk("raw_rdata", cpu_rdata, 32'hDEAD_BEEF);
    step();

    // Starvation guard
    do_reset();
    wr_req = 1; cpu_req = 1; cpu_addr = 12'h3;
    for (int k = 0; k < 20; k++) begin
      wr_addr = AW'(k + 32); wr_data = $urandom;
      step();
      exp_c = (k == 8) || (k == 17);
      chk("starve_cpu", a_gc, exp_c);
      chk("starve_wr", a_gw, !exp_c);
    end
    idle_reqs();
    repeat (3) step();

    // Reset while a read is in flight
    wr_req = 1; wr_addr = 12'h0AA; wr_data = 32'h1234_5678;
    step();
    wr_req = 0;
    vga_req = 1; vga_addr = 12'h0AA;
    step();
    chk("mf_vga_gnt", a_gv, 1);
    vga_req = 0;
    wr_req = 1; cpu_req = 1; cpu_addr = 12'h7;
    #2;
    rst = 1'b1;
    #1;
    chk("mf_wr_gnt0", wr_gnt, 0);
    chk("mf_cpu_gnt0", cpu_gnt, 0);
    chk("mf_addr0", mem_addr, 0);
    chk("mf_we0", mem_we, 0);
    chk("mf_wdata0", mem_wdata, 0);
    chk("mf_rvalid0", {vga_rvalid, cpu_rvalid}, 0);
    model_reset();
    idle_reqs();
    @(negedge clk);
    cyc++;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    vga_req = 1; cpu_req = 1;
    vga_addr = 12'h011; cpu_addr = 12'h022;
    step();
    chk("mf_first_vga", a_gv, 1);
    idle_reqs();
    repeat (3) step();

    // Idle
    hold_addr = mem_addr;
    repeat (10) begin
      step();
      chk("idle_we", mem_we, 0);
    end
    chk("idle_hold", mem_addr, hold_addr);

    // Randomized traffic
    for (int blk = 0; blk < 8; blk++) begin
      pw = $urandom_range(10, 100);
      pv = $urandom_range(5, 100);
      pc = $urandom_range(5, 100);
      for (int k = 0; k < 250; k++) begin
        if (!wr_req || a_gw) begin
          wr_req  = ($urandom_range(1, 100) <= pw);
          wr_addr = AW'($urandom_range(0, 15));
          wr_data = $urandom;
        end
        if (!vga_req || a_gv) begin
          vga_req  = ($urandom_range(1, 100) <= pv);
          vga_addr = AW'($urandom_range(0, 15));
        end
        if (!cpu_req || a_gc) begin
          cpu_req  = ($urandom_range(1, 100) <= pc);
          cpu_addr = AW'($urandom_range(0, 15));
        end
        step();
      end
    end
    idle_reqs();
    repeat (4) step();
    chk("drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sig_mem_arbiter.md
# sig_mem_arbiter

Single-cycle arbiter sharing the signal-sample memory (4096 × 32, one synchronous port) among three requesters. The requesters are the ADC sample writer, the VGA waveform fetcher and the CPU load path. Writes have priority so samples are never dropped, and a starvation guard bounds reader wait. The two readers alternate round-robin. The block drives the memory's address, write-enable and write-data pins from registers and steers read data back to the requester that issued it.

## Interface
- ADDR_WIDTH, 12, sample memory address width
- DATA_WIDTH, 32, sample word width
- RD_LATENCY, 1, memory cycles from registered mem_addr to valid mem_rdata (1–4)
- STARVE_LIMIT, 8, consecutive blocked cycles after which a waiting reader beats the writer (≥1)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- wr_req / wr_gnt  in / out  1  ADC writer request / grant
- wr_addr, wr_data  in  ADDR_WIDTH, DATA_WIDTH  write address and data
- vga_req / vga_gnt  in / out  1  VGA read request / grant
- vga_addr  in  ADDR_WIDTH  VGA read address
- vga_rvalid  out  1  VGA read data valid
- vga_rdata  out  DATA_WIDTH  VGA read data
- cpu_req / cpu_gnt  in / out  1  CPU read request / grant
- cpu_addr  in  ADDR_WIDTH  CPU read address
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_WIDTH  CPU read data
- mem_addr  out  ADDR_WIDTH  registered memory address
- mem_we  out  1  registered write enable
- mem_wdata  out  DATA_WIDTH  registered write data
- mem_rdata  in  DATA_WIDTH  memory read data

## Operation
- **Handshake.** Requester holds req and its addr/data stable until it sees gnt. A transfer occurs at any rising edge where req && gnt. gnt is combinational from the reqs and arbiter state. At most one gnt is high per cycle, and all gnts are 0 while reset is high.
- **Priority, normal case.** Writer wins whenever wr_req is high.
  - Exception: if starve_cnt == STARVE_LIMIT and any reader requests, the reader side wins for that cycle.
- **Reader choice.** Round-robin via rr_last (last reader granted, reset = CPU, so VGA wins first).
  - Both readers requesting: grant the one not equal to rr_last.
  - One reader requesting: grant it.
  - rr_last updates only on a reader transfer.
- **Starvation counter (starve_cnt, 0..STARVE_LIMIT, saturating).**
  - +1 on each cycle any reader requests while the writer is granted.
  - Cleared on any reader transfer.
  - Held otherwise.
- **Issue.** On a transfer, the edge loads:
  - mem_addr ← granted addr;
  - mem_we ← 1 for a write, 0 for a read;
  - mem_wdata ← wr_data for a write, held otherwise.
  
  With no transfer, mem_we ← 0 and mem_addr/mem_wdata hold.
- **Return.** A tag pipeline RD_LATENCY deep carries {valid, is_vga} for each read issue.
  - vga_rvalid/cpu_rvalid are decoded from the pipeline output.
  - vga_rdata and cpu_rdata are both wired straight to mem_rdata and are meaningful only with the matching rvalid.
  - Writes produce no rvalid.
- **Ordering.** Memory accesses occur in grant order. A read granted after a write to the same address returns the new data.
- **Reset (asynchronous).** mem_addr=0, mem_we=0, mem_wdata=0, both rvalid=0, tag pipeline cleared, starve_cnt=0, rr_last=CPU.
  - In-flight reads are discarded; no rvalid appears for them after reset releases.

## Timing
- Accept at edge E0 → mem_addr/mem_we valid in cycle E0→E1 → rvalid and data valid in cycle E(RD_LATENCY)→E(RD_LATENCY+1). With the default this is the cycle right after mem_addr is presented.
- Full throughput: one access per cycle; back-to-back reads pipeline with no bubbles.
- A write occupies exactly one cycle: mem_we is a single-cycle pulse per write transfer.
- Worst-case reader wait under continuous writes: STARVE_LIMIT+1 cycles.
- Worst-case reader wait under continuous opposing-reader traffic: 1 cycle.
- Simultaneous requests, starve_cnt < STARVE_LIMIT: writer granted; readers' reqs held.
- Simultaneous requests, starve_cnt == STARVE_LIMIT: reader (round-robin) granted; starve_cnt cleared the same edge.

## Test plan
- **Single read.** Memory model returns data = {20'h0, addr}. After reset, vga_req=1, vga_addr=0x559 for one cycle.
  - Required: vga_gnt=1 that cycle; mem_addr=0x559, mem_we=0 next cycle.
  - Required: vga_rvalid=1 with vga_rdata=0x00000559 the cycle after; cpu_rvalid stays 0.
- **Reader round-robin.** vga_req and cpu_req held high for 6 cycles.
  - Required: grants VGA, CPU, VGA, CPU, VGA, CPU; rvalids follow in the same order, each 2 cycles after its grant.
- **Write vs. read.** wr_req (addr 0x010, data 0xDEADBEEF) and cpu_req (addr 0x010) asserted together.
  - Required: wr_gnt first, mem_we single-cycle pulse; cpu_gnt the next cycle; cpu_rdata=0xDEADBEEF with cpu_rvalid.
- **Starvation.** STARVE_LIMIT=8; wr_req held continuously from cycle 0; cpu_req asserted from cycle 0.
  - Required: wr_gnt for cycles 0–7, cpu_gnt in cycle 8, wr_gnt from cycle 9 on; cpu_gnt again in cycle 17.
- **Reset mid-flight.** Reset asserted asynchronously one cycle after a VGA read is accepted.
  - Required: all outputs 0 immediately; no vga_rvalid after release; first grant after release goes to VGA when both readers request.
- **Idle.** No requests for 10 cycles.
  - Required: mem_we=0 throughout, mem_addr holds its last value, no rvalid, starve_cnt stays 0.
